parity_stream_acc: RTL and testbench

Streaming parity generator/checker, the sequential successor to the combinational N-bit XOR reduction. Accepts a frame of DATA_WIDTH-bit words over a valid/ready handshake and accumulates the XOR of every bit across the frame. At frame end it presents one result: the parity bit (even or odd mode), a mismatch flag against a supplied expected bit, and the frame beat count. Sits between a datapath source and a status/sink stage in the CPU memory/bus path.

---
 rtl/parity_stream_acc.sv | 138 +++++++++++++
 tb/tb_parity_stream_acc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_stream_acc.sv
// Streaming parity accumulator: XOR of every bit across a frame, result with mismatch flag and beat count.
// Latency: result valid one cycle after the last-beat input handshake.
// Backpressure: in_ready_o is low while a result is held; the result holds until out_ready_i accepts it.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   in_valid_i/in_ready_o   input word handshake; in_data_i, in_last_i, in_exp_i, mode_odd_i qualify it
//   out_valid_o/out_ready_i result handshake; out_parity_o, out_err_o, out_beats_o carry the result
//   err_cnt_o               saturating count of accepted error results (only with PARITY_ERR_CNT_EN)
//
// Optional feature macro: PARITY_ERR_CNT_EN adds the err_cnt_o port and its counter.

module parity_stream_acc #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_last_i,
    input  logic                  in_exp_i,
    input  logic                  mode_odd_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_parity_o,
    output logic                  out_err_o,
    output logic [CNT_WIDTH-1:0]  out_beats_o
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  err_cnt_o
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic                 acc;
    logic                 mode_lat;
    logic [CNT_WIDTH-1:0] beats;

    logic                 in_hs;
    logic                 out_hs;
    logic                 word_par;
    logic                 first_beat;
    logic                 frame_mode;
    logic                 acc_nxt;
    logic                 par_nxt;
    logic [CNT_WIDTH-1:0] beats_inc;

    assign in_hs      = in_valid_i & in_ready_o;
    assign out_hs     = out_valid_o & out_ready_i;
    assign word_par   = ^in_data_i;
    // beats saturates rather than wraps, so zero only ever means "no beat accepted yet".
    assign first_beat = (beats == '0);
    // A single-beat frame has no latched mode yet, so take it straight from the port.
    assign frame_mode = first_beat ? mode_odd_i : mode_lat;
    assign acc_nxt    = acc ^ word_par;
    assign par_nxt    = acc_nxt ^ frame_mode;
    assign beats_inc  = (beats == CNT_MAX) ? beats : beats + 1'b1;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (in_hs && in_last_i) state_nxt = HOLD;
            HOLD:  if (out_hs)             state_nxt = ACCUM;
            default:                       state_nxt = ACCUM;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready_o  = (state == ACCUM);
        out_valid_o = (state == HOLD);
    end

    // Datapath: accumulator, beat counter, mode latch and registered result.
    // acc/beats are left untouched on the last beat and cleared when the result
    // leaves, so the next frame always starts from a clean slate.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc          <= 1'b0;
            beats        <= '0;
            mode_lat     <= 1'b0;
            out_parity_o <= 1'b0;
            out_err_o    <= 1'b0;
            out_beats_o  <= '0;
        end else begin
            if (in_hs) begin
                if (in_last_i) begin
                    out_parity_o <= par_nxt;
                    out_err_o    <= par_nxt ^ in_exp_i;
                    out_beats_o  <= beats_inc;
                end else begin
                    acc   <= acc_nxt;
                    beats <= beats_inc;
                    if (first_beat) begin
                        mode_lat <= mode_odd_i;
                    end
                end
            end
            if (out_hs) begin
                acc   <= 1'b0;
                beats <= '0;
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    // Counts only results actually taken by the sink; a result dropped by reset is lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_o <= '0;
        end else if (out_hs && out_err_o && (err_cnt_o != CNT_MAX)) begin
            err_cnt_o <= err_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_parity_stream_acc.sv
module tb_parity_stream_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_last;
    logic        in_exp;
    logic        mode_odd;
    logic        out_ready;

    logic        rdy1, vld1, par1, err1;
    logic [15:0] beats1;
    logic        rdy2, vld2, par2, err2;
    logic [1:0]  beats2;
`ifdef PARITY_ERR_CNT_EN
    logic [15:0] ecnt1;
    logic [1:0]  ecnt2;
`endif

    int tests = 0;
    int fails = 0;
    logic [63:0] fq[$];
    int m_ecnt1 = 0;
    int m_ecnt2 = 0;

    always #5 clk = ~clk;

    parity_stream_acc #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy1),
        .in_data_i(in_data), .in_last_i(in_last), .in_exp_i(in_exp), .mode_odd_i(mode_odd),
        .out_valid_o(vld1), .out_ready_i(out_ready), .out_parity_o(par1), .out_err_o(err1),
        .out_beats_o(beats1)
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt_o(ecnt1)
`endif
    );

    // Narrow-counter instance shares all stimulus; it stays in lockstep with dut1.
    parity_stream_acc #(.DATA_WIDTH(64), .CNT_WIDTH(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy2),
        .in_data_i(in_data), .in_last_i(in_last), .in_exp_i(in_exp), .mode_odd_i(mode_odd),
        .out_valid_o(vld2), .out_ready_i(out_ready), .out_parity_o(par2), .out_err_o(err2),
        .out_beats_o(beats2)
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt_o(ecnt2)
`endif
    );

    // Reference: parity is the popcount of every frame bit, inverted in odd mode.
    function automatic bit model_parity(input bit mode);
        int ones = 0;
        foreach (fq[i]) ones += $countones(fq[i]);
        return bit'(ones % 2) ^ mode;
    endfunction

    function automatic int model_beats(input int maxv);
        return (fq.size() > maxv) ? maxv : fq.size();
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ecnt1 = 0;
        m_ecnt2 = 0;
    endtask

    // Sends the words in fq; mode is presented only on the first beat, later beats get random noise.
    task automatic drive_frame(input bit mode, input bit exp_bit);
        for (int i = 0; i < fq.size(); i++) begin
            int guard = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = fq[i];
            in_last  = (i == fq.size() - 1);
            in_exp   = in_last ? exp_bit : 1'($urandom);
            mode_odd = (i == 0) ? mode : 1'($urandom);
            while (!rdy1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!rdy1) begin
                tests++; fails++;
                $display("FAIL in_ready_timeout got %0b want 1", rdy1);
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take_result(input bit e);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        if (e) begin
            if (m_ecnt1 < 65535) m_ecnt1++;
            if (m_ecnt2 < 3) m_ecnt2++;
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (vld1 !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %0b want 0", vld1); end
        tests++; if (par1 !== 1'b0) begin fails++; $display("FAIL rst_parity got %0b want 0", par1); end
        tests++; if (err1 !== 1'b0) begin fails++; $display("FAIL rst_err got %0b want 0", err1); end
        tests++; if (beats1 !== 16'd0) begin fails++; $display("FAIL rst_beats got %0d want 0", beats1); end
        tests++; if (rdy1 !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %0b want 1", rdy1); end
`ifdef PARITY_ERR_CNT_EN
        tests++; if (ecnt1 !== 16'd0) begin fails++; $display("FAIL rst_err_cnt got %0d want 0", ecnt1); end
`endif
    endtask

    task automatic test_even_frame();
        fq = '{64'h1, 64'h3, 64'h7};
        drive_frame(1'b0, 1'b0);
        tests++; if (vld1 !== 1'b1) begin fails++; $display("FAIL even_valid got %0b want 1", vld1); end
        tests++; if (par1 !== 1'b0) begin fails++; $display("FAIL even_parity got %0b want 0", par1); end
        tests++; if (err1 !== 1'b0) begin fails++; $display("FAIL even_err got %0b want 0", err1); end
        tests++; if (beats1 !== 16'd3) begin fails++; $display("FAIL even_beats got %0d want 3", beats1); end
        take_result(1'b0);
    endtask

    task automatic test_odd_single();
        for (int k = 0; k < 2; k++) begin
            fq = '{64'hFFFF_FFFF_FFFF_FFFE};
            drive_frame(1'b1, 1'(k));
            tests++; if (par1 !== 1'b0) begin fails++; $display("FAIL odd_parity got %0b want 0", par1); end
            tests++; if (err1 !== 1'(k)) begin fails++; $display("FAIL odd_err got %0b want %0d", err1, k); end
            tests++; if (beats1 !== 16'd1) begin fails++; $display("FAIL odd_beats got %0d want 1", beats1); end
            take_result(1'(k));
`ifdef PARITY_ERR_CNT_EN
            tests++; if (ecnt1 !== 16'(m_ecnt1)) begin fails++; $display("FAIL odd_err_cnt got %0d want %0d", ecnt1, m_ecnt1); end
`endif
        end
    endtask

    task automatic test_backpressure();
        bit ep;
        int eb;
        fq = '{};
        for (int i = 0; i < 3; i++) fq.push_back({$urandom, $urandom});
        drive_frame(1'b0, 1'b1);
        ep = model_parity(1'b0);
        eb = model_beats(65535);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_last = 1'b1; in_data = {$urandom, $urandom};
            tests++; if (rdy1 !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %0b want 0", rdy1); end
            tests++; if (vld1 !== 1'b1) begin fails++; $display("FAIL bp_valid got %0b want 1", vld1); end
            tests++; if (par1 !== ep) begin fails++; $display("FAIL bp_parity got %0b want %0b", par1, ep); end
            tests++; if (err1 !== ~ep) begin fails++; $display("FAIL bp_err got %0b want %0b", err1, ~ep); end
            tests++; if (beats1 !== 16'(eb)) begin fails++; $display("FAIL bp_beats got %0d want %0d", beats1, eb); end
        end
        in_valid = 1'b0; in_last = 1'b0;
        take_result(~ep);
        tests++; if (rdy1 !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %0b want 1", rdy1); end
        tests++; if (vld1 !== 1'b0) begin fails++; $display("FAIL bp_release_valid got %0b want 0", vld1); end
        fq = '{64'h0, 64'h1};
        drive_frame(1'b0, 1'b1);
        tests++; if (par1 !== 1'b1) begin fails++; $display("FAIL bp_next_parity got %0b want 1", par1); end
        tests++; if (beats1 !== 16'd2) begin fails++; $display("FAIL bp_next_beats got %0d want 2", beats1); end
        take_result(1'b0);
    endtask

    task automatic test_mid_reset();
        fq = '{64'h1, 64'h1};
        @(negedge clk);
        in_valid = 1'b1; in_data = 64'h1; in_last = 1'b0; mode_odd = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        do_reset();
        fq = '{64'h0};
        drive_frame(1'b0, 1'b0);
        tests++; if (par1 !== 1'b0) begin fails++; $display("FAIL midrst_parity got %0b want 0", par1); end
        tests++; if (beats1 !== 16'd1) begin fails++; $display("FAIL midrst_beats got %0d want 1", beats1); end
        take_result(1'b0);
    endtask

    task automatic test_saturation();
        fq = '{64'h1, 64'h1, 64'h1, 64'h1, 64'h1};
        drive_frame(1'b0, 1'b0);
        tests++; if (beats2 !== 2'd3) begin fails++; $display("FAIL sat_beats got %0d want 3", beats2); end
        tests++; if (par2 !== 1'b1) begin fails++; $display("FAIL sat_parity got %0b want 1", par2); end
        tests++; if (beats1 !== 16'd5) begin fails++; $display("FAIL sat_wide_beats got %0d want 5", beats1); end
        take_result(1'b1);
    endtask

    task automatic test_err_cnt();
        do_reset();
        for (int f = 0; f < 4; f++) begin
            bit m;
            m = 1'($urandom);
            fq = '{{$urandom, $urandom}};
            drive_frame(m, ~model_parity(m));
            tests++; if (err2 !== 1'b1) begin fails++; $display("FAIL errcnt_err got %0b want 1", err2); end
            take_result(1'b1);
        end
`ifdef PARITY_ERR_CNT_EN
        tests++; if (ecnt2 !== 2'd3) begin fails++; $display("FAIL errcnt_sat got %0d want 3", ecnt2); end
        tests++; if (ecnt1 !== 16'd4) begin fails++; $display("FAIL errcnt_wide got %0d want 4", ecnt1); end
`endif
    endtask

    task automatic test_random();
        for (int f = 0; f < 30; f++) begin
            bit m, e, ep;
            int n;
            m = 1'($urandom);
            e = 1'($urandom);
            n = $urandom_range(1, 6);
            fq = '{};
            for (int i = 0; i < n; i++) fq.push_back({$urandom, $urandom});
            drive_frame(m, e);
            ep = model_parity(m);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            tests++; if (vld1 !== 1'b1 || vld2 !== 1'b1) begin fails++; $display("FAIL rnd_valid got %0b%0b want 11", vld1, vld2); end
            tests++; if (par1 !== ep) begin fails++; $display("FAIL rnd_parity got %0b want %0b", par1, ep); end
            tests++; if (err1 !== (ep ^ e)) begin fails++; $display("FAIL rnd_err got %0b want %0b", err1, ep ^ e); end
            tests++; if (beats1 !== 16'(model_beats(65535))) begin fails++; $display("FAIL rnd_beats got %0d want %0d", beats1, model_beats(65535)); end
            tests++; if (par2 !== ep) begin fails++; $display("FAIL rnd_parity_narrow got %0b want %0b", par2, ep); end
            tests++; if (beats2 !== 2'(model_beats(3))) begin fails++; $display("FAIL rnd_beats_narrow got %0d want %0d", beats2, model_beats(3)); end
            take_result(ep ^ e);
`ifdef PARITY_ERR_CNT_EN
            tests++; if (ecnt1 !== 16'(m_ecnt1)) begin fails++; $display("FAIL rnd_err_cnt got %0d want %0d", ecnt1, m_ecnt1); end
            tests++; if (ecnt2 !== 2'(m_ecnt2)) begin fails++; $display("FAIL rnd_err_cnt_narrow got %0d want %0d", ecnt2, m_ecnt2); end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_exp = 1'b0; mode_odd = 1'b0; out_ready = 1'b0;
        test_reset();
        test_even_frame();
        test_odd_single();
        test_backpressure();
        test_mid_reset();
        test_saturation();
        test_err_cnt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
